// File: rtl/ping_pkg.sv
// Shared state encoding, counter/product widths and default timing for the ping ranger.
package ping_pkg;

    typedef enum logic [2:0] {
        ST_TRIGGER     = 3'd0,
        ST_LISTEN_WAIT = 3'd1,
        ST_MEASURE     = 3'd2,
        ST_CALC        = 3'd3,
        ST_HOLDOFF     = 3'd4
    } state_e;

    localparam int unsigned CNT_W  = 20;
    localparam int unsigned PROD_W = 32;

    localparam int unsigned DEF_WIDTH          = 16;
    localparam int unsigned DEF_TRIG_CYCLES    = 250;
    localparam int unsigned DEF_HOLDOFF_CYCLES = 10000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;
    localparam int unsigned DEF_MM_SCALE       = 3597;
    localparam int unsigned DEF_MM_SHIFT       = 20;

endpackage

// File: rtl/ping_sync_edge.sv
// Two-flop synchronizer for the echo line plus rise/fall detection on the synced level.
module ping_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_din,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Synchronizer chain and one-cycle history for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_din;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Both edges come off the same flop pair, so rise and fall share one latency.
    assign o_level  = r_s2;
    assign o_rise_c = r_s2 & ~r_s3;
    assign o_fall_c = ~r_s2 & r_s3;

endmodule

// File: rtl/ping.sv
// Ultrasonic ranger: pulses the shared sensor line, times the echo and converts it to mm.
module ping
    import ping_pkg::*;
#(
    parameter int unsigned WIDTH          = DEF_WIDTH,
    parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned MM_SCALE       = DEF_MM_SCALE,
    parameter int unsigned MM_SHIFT       = DEF_MM_SHIFT
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire              sensor,
    output logic [WIDTH-1:0] distance,
    output logic             listening
);

    localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ECHO_SAT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [PROD_W-1:0] SCALE     = PROD_W'(MM_SCALE);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   r_echo;
    logic [CNT_W-1:0]   w_echo_nxt;
    logic [WIDTH-1:0]   r_dist;
    logic [WIDTH-1:0]   w_dist_nxt;
    logic               r_listen;
    logic               r_oe;
    logic               r_drv;
    logic               w_listen_nxt;
    logic               w_oe_nxt;
    logic               w_drv_nxt;
    logic               w_level;
    logic               w_rise;
    logic               w_fall;
    logic [PROD_W-1:0]  w_prod;
    logic [WIDTH-1:0]   w_dist_calc;

    ping_sync_edge u_sync (
        .clk      (clk),
        .reset    (reset),
        .i_din    (sensor),
        .o_level  (w_level),
        .o_rise_c (w_rise),
        .o_fall_c (w_fall)
    );

    // Echo cycles to millimetres in fixed point.
    assign w_prod      = PROD_W'(r_echo) * SCALE;
    assign w_dist_calc = WIDTH'(w_prod >> MM_SHIFT);

    // Sensor line is released only while listening; the driven level tracks the trigger.
    assign sensor    = r_oe ? r_drv : 1'bz;
    assign distance  = r_dist;
    assign listening = r_listen;

    // State, counters and registered line controls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_TRIGGER;
            r_cnt    <= '0;
            r_echo   <= '0;
            r_dist   <= '0;
            r_listen <= 1'b0;
            r_oe     <= 1'b1;
            r_drv    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_echo   <= w_echo_nxt;
            r_dist   <= w_dist_nxt;
            r_listen <= w_listen_nxt;
            r_oe     <= w_oe_nxt;
            r_drv    <= w_drv_nxt;
        end
    end

    // Next-state, counter and distance update; line controls decode the next state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_echo_nxt  = r_echo;
        w_dist_nxt  = r_dist;
        case (r_state)
            ST_TRIGGER: begin
                // The cycle right after reset is not yet driving high, so it is not counted.
                if (r_drv) begin
                    if (r_cnt == TRIG_LAST) begin
                        w_state_nxt = ST_LISTEN_WAIT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_LISTEN_WAIT: begin
                if (r_cnt == TMO_LAST) begin
                    w_dist_nxt  = '1;
                    w_state_nxt = ST_HOLDOFF;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (w_rise) begin
                        w_state_nxt = ST_MEASURE;
                        w_echo_nxt  = CNT_W'(1);
                    end
                end
            end
            ST_MEASURE: begin
                if (w_fall) begin
                    w_state_nxt = ST_CALC;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TMO_LAST) begin
                    w_dist_nxt  = '1;
                    w_state_nxt = ST_HOLDOFF;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (w_level && (r_echo != ECHO_SAT)) begin
                        w_echo_nxt = r_echo + CNT_W'(1);
                    end
                end
            end
            ST_CALC: begin
                w_dist_nxt  = w_dist_calc;
                w_state_nxt = ST_HOLDOFF;
                w_cnt_nxt   = '0;
            end
            ST_HOLDOFF: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_TRIGGER;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_TRIGGER;
                w_cnt_nxt   = '0;
            end
        endcase
        w_listen_nxt = (w_state_nxt == ST_LISTEN_WAIT) || (w_state_nxt == ST_MEASURE);
        w_oe_nxt     = ~w_listen_nxt;
        w_drv_nxt    = (w_state_nxt == ST_TRIGGER);
    end

endmodule

// File: tb/tb_ping.sv
// Directed bench for the ping ranger with shortened holdoff and timeout.
module tb_ping;

    localparam int WIDTH = 16;
    localparam int TRIG  = 250;
    localparam int HOLD  = 1000;
    localparam int TMO   = 30000;

    logic             clk     = 1'b0;
    logic             reset   = 1'b0;
    logic             tb_echo = 1'b0;
    wire              sensor;
    logic [WIDTH-1:0] distance;
    logic             listening;

    int checks = 0;
    int errors = 0;

    // The sensor model answers only while the controller has released the line.
    assign sensor = listening ? tb_echo : 1'bz;

    ping #(
        .WIDTH          (WIDTH),
        .TRIG_CYCLES    (TRIG),
        .HOLDOFF_CYCLES (HOLD),
        .TIMEOUT_CYCLES (TMO),
        .MM_SCALE       (3597),
        .MM_SHIFT       (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sensor    (sensor),
        .distance  (distance),
        .listening (listening)
    );

    always #10 clk = ~clk;

    // Echo pulse of len cycles after pre idle cycles; returns cycles until listening drops.
    task automatic do_echo(input int pre, input int len, output int lat);
        repeat (pre) @(negedge clk);
        tb_echo = 1'b1;
        repeat (len) @(negedge clk);
        tb_echo = 1'b0;
        lat = 0;
        while (listening && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Counts driven-low cycles up to the retrigger, then high cycles up to the next listen window.
    task automatic count_gap(output int hold_n, output int trig_n);
        hold_n = 0;
        while (sensor !== 1'b1 && hold_n < HOLD + 100) begin
            hold_n++;
            @(negedge clk);
        end
        trig_n = 0;
        while (!listening && trig_n < TRIG + 100) begin
            trig_n++;
            @(negedge clk);
        end
    endtask

    // Counts trigger-high cycles from a reset release to the first listen window.
    task automatic count_trigger(output int n);
        int k;
        n = 0;
        k = 0;
        while (!listening && k < TRIG + 100) begin
            @(negedge clk);
            k++;
            if (!listening && sensor === 1'b1) n++;
        end
    endtask

    task automatic test_reset();
        int n;
        reset   = 1'b0;
        tb_echo = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (listening !== 1'b0) begin errors++; $display("FAIL reset_listening: got %0b expected 0", listening); end
        checks++; if (sensor !== 1'b0) begin errors++; $display("FAIL reset_sensor: got %0b expected 0", sensor); end
        checks++; if (distance !== 16'h0000) begin errors++; $display("FAIL reset_distance: got %0h expected 0", distance); end
        reset = 1'b1;
        count_trigger(n);
        checks++; if (n != TRIG) begin errors++; $display("FAIL first_trigger_len: got %0d expected %0d", n, TRIG); end
        checks++; if (listening !== 1'b1) begin errors++; $display("FAIL first_listen: got %0b expected 1", listening); end
        checks++; if (distance !== 16'h0000) begin errors++; $display("FAIL first_distance: got %0h expected 0", distance); end
    endtask

    task automatic test_zero_echo();
        int lat, hold_n, trig_n;
        do_echo(4700, 250, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL zero_calc_latency: got %0d expected 3", lat); end
        count_gap(hold_n, trig_n);
        checks++; if (hold_n != HOLD + 1) begin errors++; $display("FAIL zero_holdoff: got %0d expected %0d", hold_n, HOLD + 1); end
        checks++; if (distance !== 16'd0) begin errors++; $display("FAIL zero_distance: got %0d expected 0", distance); end
        checks++; if (trig_n != TRIG) begin errors++; $display("FAIL zero_retrigger: got %0d expected %0d", trig_n, TRIG); end
    endtask

    task automatic test_boundary();
        int lens [4] = '{292, 291, 292, 1};
        int exps [4] = '{1, 0, 1, 0};
        int lat, hold_n, trig_n;
        for (int i = 0; i < 4; i++) begin
            do_echo(100, lens[i], lat);
            checks++; if (lat != 3) begin errors++; $display("FAIL boundary_latency[%0d]: got %0d expected 3", i, lat); end
            count_gap(hold_n, trig_n);
            checks++; if (distance !== WIDTH'(exps[i])) begin errors++; $display("FAIL boundary_distance len=%0d: got %0d expected %0d", lens[i], distance, exps[i]); end
        end
    endtask

    task automatic test_echo_100mm();
        int lat, hold_n, trig_n;
        do_echo(100, 29155, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL mm100_latency: got %0d expected 3", lat); end
        count_gap(hold_n, trig_n);
        checks++; if (distance !== 16'd100) begin errors++; $display("FAIL mm100_distance: got %0d expected 100", distance); end
        checks++; if (hold_n != HOLD + 1) begin errors++; $display("FAIL mm100_holdoff: got %0d expected %0d", hold_n, HOLD + 1); end
    endtask

    task automatic test_high_at_entry();
        int lat, hold_n, trig_n;
        tb_echo = 1'b1;
        repeat (200) @(negedge clk);
        tb_echo = 1'b0;
        do_echo(100, 292, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL entry_latency: got %0d expected 3", lat); end
        count_gap(hold_n, trig_n);
        checks++; if (distance !== 16'd1) begin errors++; $display("FAIL entry_distance: got %0d expected 1", distance); end
    endtask

    task automatic test_timeout();
        int n, hold_n, trig_n;
        tb_echo = 1'b0;
        n = 0;
        while (listening && n < TMO + 100) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n != TMO) begin errors++; $display("FAIL timeout_window: got %0d expected %0d", n, TMO); end
        checks++; if (distance !== 16'hFFFF) begin errors++; $display("FAIL timeout_distance: got %0h expected ffff", distance); end
        count_gap(hold_n, trig_n);
        checks++; if (hold_n != HOLD) begin errors++; $display("FAIL timeout_holdoff: got %0d expected %0d", hold_n, HOLD); end
        checks++; if (trig_n != TRIG) begin errors++; $display("FAIL timeout_retrigger: got %0d expected %0d", trig_n, TRIG); end
    endtask

    task automatic test_reset_mid_echo();
        int n, lat, hold_n, trig_n;
        repeat (100) @(negedge clk);
        tb_echo = 1'b1;
        repeat (100) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (listening !== 1'b0) begin errors++; $display("FAIL abort_listening: got %0b expected 0", listening); end
        checks++; if (sensor !== 1'b0) begin errors++; $display("FAIL abort_sensor: got %0b expected 0", sensor); end
        checks++; if (distance !== 16'h0000) begin errors++; $display("FAIL abort_distance: got %0h expected 0", distance); end
        tb_echo = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        count_trigger(n);
        checks++; if (n != TRIG) begin errors++; $display("FAIL abort_retrigger: got %0d expected %0d", n, TRIG); end
        checks++; if (distance !== 16'h0000) begin errors++; $display("FAIL abort_hold_zero: got %0h expected 0", distance); end
        do_echo(100, 292, lat);
        count_gap(hold_n, trig_n);
        checks++; if (distance !== 16'd1) begin errors++; $display("FAIL abort_next_distance: got %0d expected 1", distance); end
    endtask

    initial begin
        test_reset();
        test_zero_echo();
        test_boundary();
        test_echo_100mm();
        test_high_at_entry();
        test_timeout();
        test_reset_mid_echo();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ping.md
PING -- requirements
Module: ping

Interface
REQ-001 Parameter WIDTH, 16, width of distance output in mm.
REQ-002 Parameter TRIG_CYCLES, 250, trigger pulse length in clk cycles (5 us at 50 MHz).
REQ-003 Parameter HOLDOFF_CYCLES, 10000, idle gap between measurements (200 us).
REQ-004 Parameter TIMEOUT_CYCLES, 1000000, listen window from end of trigger (20 ms); counter is 20 bits.
REQ-005 Parameter MM_SCALE, 3597, fixed-point cycles-to-mm factor (343 m/s round trip at 50 MHz, Q0.20).
REQ-006 Parameter MM_SHIFT, 20, right-shift applied after the MM_SCALE multiply.
REQ-007 Port clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-008 Port reset  input  1  asynchronous, active-low reset.
REQ-009 Port sensor  inout  1  single-wire ultrasonic sensor line; trigger out, echo in.
REQ-010 Port distance  output  WIDTH  last measured object distance in mm.
REQ-011 Port listening  output  1  high while the block has released sensor and samples echo.

Function
REQ-012 The FSM SHALL have states TRIGGER, LISTEN_WAIT, MEASURE, CALC, HOLDOFF.
- TRIGGER: drive sensor=1 for TRIG_CYCLES cycles, then go to LISTEN_WAIT.
- LISTEN_WAIT: wait for a synchronized echo rising edge, then go to MEASURE.
- MEASURE: count cycles while echo is high; a falling edge goes to CALC.
- CALC: one cycle; latch distance, then go to HOLDOFF.
- HOLDOFF: drive sensor=0 for HOLDOFF_CYCLES cycles, then go to TRIGGER.
REQ-013 sensor SHALL be driven in TRIGGER/HOLDOFF/CALC (1 in TRIGGER, else 0) and SHALL be high-Z in LISTEN_WAIT and MEASURE.
REQ-014 listening SHALL be 1 exactly in LISTEN_WAIT and MEASURE, registered, coincident with the sensor release.
REQ-015 The sensor input SHALL pass through a 2-flop synchronizer before edge detection; both edges see equal latency, so the width is unbiased.
REQ-016 Echo width SHALL be counted in a 20-bit counter saturating at TIMEOUT_CYCLES.
REQ-017 In CALC, distance SHALL equal (echo_cycles * MM_SCALE) >> MM_SHIFT, using a 32-bit product, truncated to WIDTH bits.
REQ-018 distance SHALL update only in CALC and hold its value otherwise.
REQ-019 The listen window starts on entering LISTEN_WAIT and spans LISTEN_WAIT plus MEASURE.
- If it exceeds TIMEOUT_CYCLES (no echo, or echo stuck high), distance SHALL be set to all-ones (no object).
- The FSM then goes directly to HOLDOFF.
REQ-020 An echo already high on entering LISTEN_WAIT SHALL NOT start a measurement; only a low-to-high transition starts one.
REQ-021 An echo of one synchronized cycle SHALL measure as 1 cycle; distance 0 is a valid result.

Reset
REQ-022 While reset=0, the block SHALL force:
- state=TRIGGER with its counter cleared;
- listening=0, sensor driven 0;
- distance=0, synchronizer flops=0.
REQ-023 After reset deassertion, the first trigger pulse SHALL start on the first clk edge.
REQ-024 Reset asserted mid-measurement SHALL abort immediately and discard the partial count.

Structure
REQ-025 The state encoding and timing/scale defaults SHALL live in a shared package ping_pkg.
REQ-026 The synchronizer plus edge detector SHALL be one sub-module, ping_sync_edge.
- Outputs: sync level, rise pulse, fall pulse.

Verification
REQ-027 Reset release -> sensor=1 for 250 cycles, then listening=1 and sensor=Z; distance=0.
REQ-028 Echo of 250 cycles starting 5000 cycles after reset -> CALC fires, distance=0, then 10000-cycle holdoff, then retrigger.
REQ-029 Echo of 29155 cycles -> distance=100.
REQ-030 Echo of 925000 cycles -> distance=3173.
REQ-031 No echo -> after 1000000 listen cycles distance=16'hFFFF, listening=0, holdoff then retrigger.
REQ-032 Reset asserted at mid-echo -> listening=0 and sensor=0 at once; after release, a fresh trigger; distance=0 until the next valid measurement.
